// File: rtl/ms_arb_pkg.sv
// Shared types for the ms_if write arbiter: bus field widths and FSM state encoding.
// No logic; no latency.
// No flow control of its own.
package ms_arb_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    typedef logic [ADDR_W-1:0] ms_addr_t;
    typedef logic [DATA_W-1:0] ms_data_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        ABORT = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among N level requests, searching upward from ptr with wraparound.
// Purely combinational, zero latency.
// No backpressure; the owner decides when a pick is consumed and advances ptr.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] winner,
    output logic          valid
);

    logic [IW-1:0] idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            idx = IW'((int'(ptr) + i) % N);
            if (enable && !valid && req[idx]) begin
                valid      = 1'b1;
                winner     = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ms_write_arbiter.sv
// Shares one ms_if master port among NUM_REQ register-write requesters, round-robin.
// Grant 1 cycle after req, DATA (done) 1 cycle after sready; back-to-back writes skip IDLE.
// Holds the address phase while sready is low; aborts with err after WAIT_MAX cycles.
module ms_write_arbiter
    import ms_arb_pkg::*;
#(
    parameter int       NUM_REQ   = 4,
    parameter ms_addr_t IDLE_ADDR = 4'hF,
    parameter int       WAIT_MAX  = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [NUM_REQ-1:0]        err,
    output logic                      busy,
    output ms_addr_t                  m_addr,
    output ms_data_t                  m_data,
    input  logic                      m_sready
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(WAIT_MAX + 1);

    state_t             state, state_d;
    logic [NUM_REQ-1:0] gnt_q, arb_gnt;
    logic [IW-1:0]      rr_ptr, arb_idx;
    logic               arb_vld, arb_en, take;
    ms_addr_t           addr_q, sel_addr;
    ms_data_t           data_q, sel_data;
    logic [CW-1:0]      wait_cnt;

    // gnt_q masks the current winner so it cannot win again from its own DATA cycle
    assign arb_en = (state == IDLE) || (state == DATA);

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req    (req & ~gnt_q),
        .ptr    (rr_ptr),
        .enable (arb_en),
        .grant  (arb_gnt),
        .winner (arb_idx),
        .valid  (arb_vld)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IW'(i)) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state;
        take    = 1'b0;
        case (state)
            IDLE: begin
                if (arb_vld) begin
                    state_d = ADDR;
                    take    = 1'b1;
                end
            end
            ADDR: begin
                if (m_sready)
                    state_d = DATA;
                else if (wait_cnt == CW'(WAIT_MAX - 1))
                    state_d = ABORT;
            end
            DATA: begin
                if (arb_vld) begin
                    state_d = ADDR;
                    take    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // m_data stays on the latched value so the slave sees it in the cycle after ADDR
    always_comb begin
        m_addr = (state == ADDR) ? addr_q : IDLE_ADDR;
        m_data = data_q;
        gnt    = (state == ABORT) ? '0 : gnt_q;
        done   = (state == DATA) ? gnt_q : '0;
        err    = (state == ABORT) ? gnt_q : '0;
        busy   = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt_q    <= '0;
            rr_ptr   <= '0;
            addr_q   <= IDLE_ADDR;
            data_q   <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_d;
            if (take) begin
                gnt_q    <= arb_gnt;
                addr_q   <= sel_addr;
                data_q   <= sel_data;
                wait_cnt <= '0;
                rr_ptr   <= (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            end else if (state_d == IDLE) begin
                gnt_q <= '0;
            end
            if (state == ADDR && state_d == ADDR)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: doc/ms_write_arbiter.md
Name: ms_write_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single ms_if master port (addr/data/sready) between NUM_REQ requesters.
- Each requester posts one register write (4-bit address, 8-bit data); the block drives the address phase, waits for sready, then drives the data phase.
- Sits between the register-configuration sources and the ms_if slave register bank.
- Drives a non-decoding idle address whenever no write is in progress, so the slave performs no writes while idle.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDLE_ADDR, 4'hF, address driven when idle; must not decode to a slave register.
- WAIT_MAX, 15, maximum ADDR-phase cycles with sready low before abort.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- req  input  NUM_REQ  per-requester write request, level
- req_addr  input  NUM_REQ*4  packed per-requester address (slice i = [4i+3:4i])
- req_data  input  NUM_REQ*8  packed per-requester write data (slice i = [8i+7:8i])
- gnt  output  NUM_REQ  one-hot, high from grant through DATA cycle
- done  output  NUM_REQ  one-cycle pulse, write completed
- err  output  NUM_REQ  one-cycle pulse, write aborted on timeout
- busy  output  1  state != IDLE
- m_addr  output  4  ms_if address
- m_data  output  8  ms_if data
- m_sready  input  1  ms_if slave ready (combinational from m_addr in the slave)

Behaviour:
- Reset values:
  - state = IDLE; gnt, done, err, busy = 0
  - m_addr = IDLE_ADDR; m_data = 0
  - rr_ptr = 0; wait_cnt = 0
- Slave timing contract:
  - Slave registers m_addr every cycle.
  - Slave writes the register addressed by last cycle's m_addr with this cycle's m_data.
  - Therefore m_data must hold the granted data during both ADDR and DATA.
- FSM IDLE:
  - m_addr = IDLE_ADDR.
  - If any req is high: pick the winner round-robin starting at rr_ptr.
  - Latch winner addr/data; set gnt[winner]; go to ADDR.
  - rr_ptr <= winner+1, wrapping mod NUM_REQ.
- FSM ADDR:
  - m_addr = latched addr; m_data = latched data.
  - If m_sready == 1 at the clock edge: go to DATA.
  - Else if wait_cnt == WAIT_MAX-1: go to ABORT.
  - Else wait_cnt++.
  - wait_cnt clears on entry to ADDR.
- FSM DATA (exactly 1 cycle):
  - m_addr = IDLE_ADDR; m_data = latched data; done[winner] = 1.
  - Arbitrate during this cycle. If any req other than the current winner is high, grant it and go directly to ADDR (back-to-back writes, no IDLE bubble).
  - Otherwise go to IDLE and clear gnt.
- FSM ABORT (exactly 1 cycle):
  - m_addr = IDLE_ADDR; err[winner] = 1; gnt cleared; go to IDLE.
  - The slave may already have written the latched data; err only signals the timeout to the requester.
- Latency: req high in IDLE at cycle 0 → ADDR cycle 1 → (sready high) DATA cycle 2 with done pulse → slave register updated at the end of cycle 2.
- The current winner's req is ignored during its own DATA cycle; a requester must drop req on done/err or it is re-queued behind the others.
- Requester inputs are sampled only at grant; changes after grant do not affect the write in progress.
- Addresses 4..14 are forwarded unchanged; the slave ignores them and done still pulses.
- An address equal to IDLE_ADDR is also forwarded and completes normally.
- Simultaneous requests: exactly one grant per arbitration; priority rotates so no requester waits more than NUM_REQ-1 writes.
- rst during any state: return to reset values on the next edge; an in-flight write is dropped and no done/err pulse is produced.
- done and err are mutually exclusive; at most one bit of gnt/done/err is set at any time.

Decomposition:
- Package ms_arb_pkg:
  - typedef ms_addr_t (logic [3:0]), ms_data_t (logic [7:0])
  - state enum {IDLE, ADDR, DATA, ABORT}
  - constants for the address/data widths.
- One sub-module: rr_arbiter (param N).
  - Inputs: req vector, ptr, enable.
  - Outputs: one-hot grant, winner index, valid.
  - Purely combinational; the owning FSM holds the pointer state.

Test Plan:
- Single write: req[0]=1, addr=1, data=8'hA5, sready tied high → gnt[0] at cycle 1, done[0] pulse at cycle 2, m_addr sequence F,1,F; slave reg_b = 8'hA5.
- Contended: req=4'b1011 held until each done → grants in order 0,1,3, then 0 again on re-request; 3 consecutive done pulses with no IDLE cycles between writes.
- Ready stall: addr=3 following an addr=3 write (slave sready low one cycle) → ADDR lasts 2 cycles, done one cycle later; reg_d updated once with the correct data.
- Timeout: m_sready forced low, req[2]=1, addr=0 → err[2] pulse after 15 ADDR cycles, no done pulse, returns to IDLE, busy=0.
- Reset mid-write: assert rst during ADDR → next cycle m_addr=F, gnt=0, busy=0, no done/err; subsequent req[1] is served normally with rr_ptr=0.
- Unmapped address: addr=4'h7, data=8'h3C → done pulses; reg_a..reg_d unchanged.
